timer60_display: RTL and testbench

Two-digit multiplexed seven-segment driver that sits directly downstream of the 0–59 timer. It takes the timer's BCD count, initial value and carry outputs and produces time-multiplexed, active-low segment and digit-enable lines. It also resynchronises and glitch-filters the timer's ripple-clocked count into its own clock domain, latches an expiry flag, and applies blinking and leading-zero blanking.

---
 rtl/timer60_display.sv | 122 ++++++++++++
 tb/tb_timer60_display.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/timer60_display.sv
// timer60_display: two-digit multiplexed seven-segment driver for the 0-59 timer
module timer60_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2,
  parameter int BLINK_SCANS = 100,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic [7:0] Count60,
  input  logic [7:0] Init_value60,
  input  logic [1:0] carry60,
  input  logic       set_time,
  input  logic       pause,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic       expired
);
  localparam int CW = $clog2(REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES);
  localparam int BW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  typedef enum logic [1:0] {S_UNIT, S_GAP0, S_DOZEN, S_GAP1} state_t;
  state_t state;
  logic [CW-1:0] slot_cnt;
  logic [BW-1:0] scan_cnt;
  logic phase;
  logic [7:0] cnt_s1, cnt_s2, cnt_f, src;
  logic car_s1, car_s2, car_s3, st_s1, st_s2;
  logic digit, last, active, blank;
  logic [6:0] unit_seg, dozen_seg;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction

  // Bring the ripple-clocked timer outputs and set_time into the Clk domain
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_s1 <= '0;
      cnt_s2 <= '0;
      car_s1 <= 1'b0;
      car_s2 <= 1'b0;
      car_s3 <= 1'b0;
      st_s1  <= 1'b0;
      st_s2  <= 1'b0;
    end else begin
      cnt_s1 <= Count60;
      cnt_s2 <= cnt_s1;
      car_s1 <= carry60[1];
      car_s2 <= car_s1;
      car_s3 <= car_s2;
      st_s1  <= set_time;
      st_s2  <= st_s1;
    end
  end

  // Accept a new count only when two consecutive samples agree, so ripple glitches never reach the display
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) cnt_f <= '0;
    else if (cnt_s1 == cnt_s2) cnt_f <= cnt_s2;
  end

  // Sticky expiry flag; a clear in the same cycle as a carry rise wins
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) expired <= 1'b0;
    else if (st_s2) expired <= 1'b0;
    else if (car_s2 && !car_s3) expired <= 1'b1;
  end

  // Select the displayed value, decode both digits and resolve slot timing
  always_comb begin
    src       = st_s2 ? Init_value60 : cnt_f;
    unit_seg  = dec(src[3:0]);
    dozen_seg = (LZ_BLANK && src[7:4] == 4'd0) ? 7'h7F : dec(src[7:4]);
    digit     = state == S_UNIT || state == S_DOZEN;
    last      = digit ? slot_cnt == CW'(REFRESH_DIV - 1) : slot_cnt == CW'(GAP_CYCLES - 1);
    active    = pause | expired;
    blank     = active & phase;
  end

  // Scan FSM with registered outputs: each edge emits the current slot, then advances
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_UNIT;
      slot_cnt <= '0;
      scan_cnt <= '0;
      phase    <= 1'b0;
      seg      <= 7'h7F;
      an       <= 2'b11;
      dp       <= 1'b1;
    end else begin
      an       <= state == S_UNIT ? 2'b10 : state == S_DOZEN ? 2'b01 : 2'b11;
      seg      <= blank ? 7'h7F : state == S_UNIT ? unit_seg : state == S_DOZEN ? dozen_seg : 7'h7F;
      dp       <= !(state == S_UNIT && st_s2);
      slot_cnt <= last ? '0 : slot_cnt + 1'b1;
      if (last) state <= state_t'(state + 2'd1);
      if (!active) begin
        phase    <= 1'b0;
        scan_cnt <= '0;
      end else if (last && state == S_DOZEN) begin
        if (scan_cnt == BW'(BLINK_SCANS - 1)) begin
          scan_cnt <= '0;
          phase    <= ~phase;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_timer60_display.sv
// tb_timer60_display: directed self-checking bench for timer60_display
module tb_timer60_display;
  logic clk, reset_n, set_time, pause;
  logic [7:0] count, init;
  logic [1:0] carry;
  logic [6:0] seg, seg_b;
  logic [1:0] an, an_b;
  logic dp, dp_b, expired, expired_b;
  int n_checks, n_fail;
  int nb, nv, ng;
  logic [1:0] prev_an;
  logic [1:0] an_exp [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};

  timer60_display #(.REFRESH_DIV(4), .GAP_CYCLES(1), .BLINK_SCANS(2), .LZ_BLANK(1'b1)) u_dut (
    .Clk(clk), .reset_n(reset_n), .Count60(count), .Init_value60(init), .carry60(carry),
    .set_time(set_time), .pause(pause), .seg(seg), .an(an), .dp(dp), .expired(expired));

  timer60_display #(.REFRESH_DIV(4), .GAP_CYCLES(1), .BLINK_SCANS(2), .LZ_BLANK(1'b0)) u_dut_nolz (
    .Clk(clk), .reset_n(reset_n), .Count60(count), .Init_value60(init), .carry60(carry),
    .set_time(set_time), .pause(pause), .seg(seg_b), .an(an_b), .dp(dp_b), .expired(expired_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic find_slot(input logic [1:0] a, input string tag);
    for (int k = 0; k < 40 && an !== a; k++) @(negedge clk);
    chk(tag, 8'(an), 8'(a));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; count = 8'h37; init = 8'h25; carry = 2'b00; set_time = 1'b0; pause = 1'b0;
    step(3);
    chk("rst_seg", 8'(seg), 8'h7F);
    chk("rst_an", 8'(an), 8'h03);
    chk("rst_dp", 8'(dp), 8'h01);
    chk("rst_expired", 8'(expired), 8'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("scan_an", 8'(an), 8'(an_exp[i]));
      if (an_exp[i] == 2'b11) chk("gap_seg", 8'(seg), 8'h7F);
    end
    find_slot(2'b10, "slot_unit37");
    chk("unit_37", 8'(seg), 8'h78);
    find_slot(2'b01, "slot_dozen37");
    chk("dozen_37", 8'(seg), 8'h30);
    chk("dozen_37_nolz", 8'(seg_b), 8'h30);
    count = 8'h05;
    step(8);
    find_slot(2'b10, "slot_unit05");
    chk("unit_05", 8'(seg), 8'h12);
    chk("unit_05_nolz", 8'(seg_b), 8'h12);
    find_slot(2'b01, "slot_dozen05");
    chk("dozen_05_lz", 8'(seg), 8'h7F);
    chk("dozen_05_nolz", 8'(seg_b), 8'h40);
    for (int i = 0; i < 20; i++) begin
      count = i[0] ? 8'h13 : 8'h12;
      @(negedge clk);
      if (an == 2'b10) chk("toggle_unit", 8'(seg), 8'h12);
      if (an == 2'b01) chk("toggle_dozen", 8'(seg), 8'h7F);
    end
    count = 8'h14;
    step(4);
    find_slot(2'b10, "slot_unit14");
    chk("unit_14", 8'(seg), 8'h19);
    find_slot(2'b01, "slot_dozen14");
    chk("dozen_14", 8'(seg), 8'h79);
    carry = 2'b10;
    step(1);
    chk("carry_edge1", 8'(expired), 8'h00);
    step(1);
    chk("carry_edge2", 8'(expired), 8'h00);
    step(1);
    chk("carry_edge3", 8'(expired), 8'h01);
    carry = 2'b00;
    step(2);
    nb = 0; nv = 0; ng = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an == 2'b11 && seg == 7'h7F) ng++;
      else if (an != 2'b11 && seg == 7'h7F) nb++;
      else if ((an == 2'b10 && seg == 7'h19) || (an == 2'b01 && seg == 7'h79)) nv++;
    end
    chk("blink_off_cycles", 8'(nb), 8'd16);
    chk("blink_on_cycles", 8'(nv), 8'd16);
    chk("blink_gap_cycles", 8'(ng), 8'd8);
    chk("expired_sticky", 8'(expired), 8'h01);
    set_time = 1'b1;
    step(2);
    chk("clear_edge2", 8'(expired), 8'h01);
    step(1);
    chk("clear_edge3", 8'(expired), 8'h00);
    step(4);
    find_slot(2'b10, "slot_unit_init");
    chk("unit_init", 8'(seg), 8'h12);
    chk("dp_unit_set", 8'(dp), 8'h00);
    find_slot(2'b01, "slot_dozen_init");
    chk("dozen_init", 8'(seg), 8'h24);
    chk("dp_dozen_set", 8'(dp), 8'h01);
    set_time = 1'b0;
    count = 8'h59;
    pause = 1'b1;
    step(3);
    for (int k = 0; k < 120; k++) begin
      prev_an = an;
      @(negedge clk);
      if (an == 2'b01 && prev_an == 2'b11 && seg == 7'h7F) break;
    end
    chk("pause_an", 8'(an), 8'h01);
    chk("pause_blank", 8'(seg), 8'h7F);
    pause = 1'b0;
    step(1);
    chk("unpause_dozen", 8'(seg), 8'h12);
    find_slot(2'b10, "slot_unit59");
    chk("unpause_unit", 8'(seg), 8'h10);
    find_slot(2'b01, "slot_dozen_rst");
    step(1);
    chk("pre_reset_an", 8'(an), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_seg", 8'(seg), 8'h7F);
    chk("async_rst_an", 8'(an), 8'h03);
    chk("async_rst_dp", 8'(dp), 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart_an", 8'(an), 8'h02);
    chk("restart_seg", 8'(seg), 8'h40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
